// File: rtl/cluster_link_scheduler.sv
// -----------------------------------------------------------------------------
// cluster_link_scheduler
//
// Purpose:
//   This block sits downstream of the 8-of-1536 cluster finder and runs at the
//   clock4x rate. On each per-BX latch_in strobe it takes the valid clusters
//   from the eight slots and packs them, lowest slot first and with no gaps,
//   into a circular FIFO. Each entry is tagged with a 12-bit BX number. A
//   valid/ready output register sends the queued clusters one per clock. A
//   small FSM (IDLE / RUN / FLUSH) handles BX0 alignment and resync.
//
// Optional feature (macro CLUSTER_SCHED_AGE_DROP_EN):
//   When the macro is defined, the block checks the head entry each time the
//   output register loads. If that entry is more than MAX_AGE BX old, it is
//   discarded and counted in overflow_cnt. When the macro is undefined, every
//   queued cluster is presented.
//
// Ports:
//   clock4x       in   160 MHz clock
//   global_reset  in   asynchronous active-high reset
//   bc0           in   BX0 marker
//   resync        in   one-cycle resync request
//   latch_in      in   per-BX load strobe
//   vpf_in[7:0]   in   per-slot valid flags
//   adr_in[87:0]  in   slot i address at [11i+10:11i]
//   cnt_in[23:0]  in   slot i size at [3i+2:3i]
//   out_ready     in   link accepts output this cycle
//   out_valid     out  output register holds a cluster
//   out_adr       out  cluster address
//   out_cnt       out  cluster size
//   out_bx        out  BX tag of the cluster
//   fifo_level    out  FIFO occupancy, not counting the output register
//   overflow_cnt  out  saturating count of dropped clusters
//   running       out  high while in RUN
// -----------------------------------------------------------------------------
module cluster_link_scheduler #(
  parameter int DEPTH   = 32,
  parameter int BX_MAX  = 3564,
  parameter int MAX_AGE = 4
) (
  input  logic                   clock4x,
  input  logic                   global_reset,
  input  logic                   bc0,
  input  logic                   resync,
  input  logic                   latch_in,
  input  logic [7:0]             vpf_in,
  input  logic [87:0]            adr_in,
  input  logic [23:0]            cnt_in,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [10:0]            out_adr,
  output logic [2:0]             out_cnt,
  output logic [11:0]            out_bx,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            overflow_cnt,
  output logic                   running
);

  localparam int PW = $clog2(DEPTH);  // pointer width
  localparam int LW = PW + 1;         // level / count width (LW >= 4 since DEPTH >= 8)
  localparam int EW = 26;             // entry: {adr[10:0], cnt[2:0], bx[11:0]}

  localparam logic [11:0] BX_LAST = 12'(BX_MAX - 1);
  localparam logic [12:0] BX_MOD  = 13'(BX_MAX);
  localparam logic [12:0] AGE_LIM = 13'(MAX_AGE);

`ifdef CLUSTER_SCHED_AGE_DROP_EN
  localparam logic AGE_DROP_EN = 1'b1;
`else
  localparam logic AGE_DROP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t         state_reg;
  logic [11:0]    bx_reg;
  logic [PW-1:0]  wr_ptr_reg;
  logic [PW-1:0]  rd_ptr_reg;
  logic [EW-1:0]  mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Slot unpacking
  // ---------------------------------------------------------------------------
  logic [10:0] slot_adr [8];
  logic [2:0]  slot_cnt [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_slot
      assign slot_adr[gi] = adr_in[11*gi +: 11];
      assign slot_cnt[gi] = cnt_in[3*gi +: 3];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Load compaction, BX counter next value and pop / age logic
  // ---------------------------------------------------------------------------
  logic [LW-1:0] slot_pos [9];   // number of valid slots below slot i
  logic [PW-1:0] slot_idx [8];
  logic [7:0]    slot_we;
  logic          load_en;
  logic [LW-1:0] free_space;
  logic [LW-1:0] n_valid;
  logic [LW-1:0] n_written;
  logic [LW-1:0] n_dropped;
  logic [11:0]   bx_base;
  logic [11:0]   bx_inc;
  logic [EW-1:0] head;
  logic [11:0]   head_bx;
  logic [12:0]   head_age;
  logic          load_out;
  logic          pop;
  logic          discard;
  logic          present;
  logic          discard_evt;
  logic [16:0]   ovf_sum;

  always_comb begin
    // bc0 zeroes the counter in RUN unless resync claims the cycle. A load in
    // the same cycle is then tagged with the zeroed value.
    bx_base = (bc0 && !resync) ? 12'd0 : bx_reg;
    bx_inc  = (bx_base == BX_LAST) ? 12'd0 : bx_base + 12'd1;

    load_en    = (state_reg == RUN) && latch_in;
    // Room is measured before this cycle's pop. A pop in the same cycle does
    // not free a slot for a write in that cycle.
    free_space = LW'(DEPTH) - fifo_level;

    slot_pos[0] = '0;
    for (int i = 0; i < 8; i++) begin
      slot_pos[i+1] = slot_pos[i] + LW'(vpf_in[i]);
    end
    n_valid = slot_pos[8];

    // If the load does not fit, the lowest-index valid slots are kept. That
    // means writing every valid slot whose compacted position is below the
    // free space.
    for (int i = 0; i < 8; i++) begin
      slot_idx[i] = wr_ptr_reg + slot_pos[i][PW-1:0];
      slot_we[i]  = load_en && vpf_in[i] && (slot_pos[i] < free_space);
    end

    if (load_en) begin
      n_written = (n_valid < free_space) ? n_valid : free_space;
      n_dropped = n_valid - n_written;
    end else begin
      n_written = '0;
      n_dropped = '0;
    end

    head    = mem[rd_ptr_reg];
    head_bx = head[11:0];
    if (bx_reg >= head_bx) begin
      head_age = {1'b0, bx_reg - head_bx};
    end else begin
      head_age = {1'b0, bx_reg} + BX_MOD - {1'b0, head_bx};
    end

    load_out    = !out_valid || out_ready;
    pop         = load_out && (fifo_level != '0);
    discard     = AGE_DROP_EN && (head_age > AGE_LIM);
    present     = pop && !discard;
    discard_evt = pop && discard;

    ovf_sum = 17'(overflow_cnt) + 17'(n_dropped) + 17'(discard_evt);
  end

  // ---------------------------------------------------------------------------
  // FIFO storage (no reset; contents are only meaningful below fifo_level)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock4x) begin
    for (int i = 0; i < 8; i++) begin
      if (slot_we[i]) begin
        mem[slot_idx[i]] <= {slot_adr[i], slot_cnt[i], bx_base};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Controller FSM with BX counter and registered running flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      state_reg <= IDLE;
      bx_reg    <= 12'd0;
      running   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bc0) begin
            bx_reg    <= 12'd0;
            state_reg <= RUN;
            running   <= 1'b1;
          end
        end
        RUN: begin
          bx_reg <= latch_in ? bx_inc : bx_base;
          if (resync) begin
            state_reg <= FLUSH;
            running   <= 1'b0;
          end
        end
        FLUSH: begin
          if ((fifo_level == '0) && !out_valid) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          running   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, level, output register, overflow counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_level   <= '0;
      out_valid    <= 1'b0;
      out_adr      <= 11'd0;
      out_cnt      <= 3'd0;
      out_bx       <= 12'd0;
      overflow_cnt <= 16'd0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + n_written[PW-1:0];
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      fifo_level <= fifo_level + n_written - LW'(pop);

      // When the output register reloads but has no head to present, the data
      // fields keep their last value and only out_valid falls.
      if (load_out) begin
        if (present) begin
          out_valid <= 1'b1;
          out_adr   <= head[25:15];
          out_cnt   <= head[14:12];
          out_bx    <= head[11:0];
        end else begin
          out_valid <= 1'b0;
        end
      end

      overflow_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end
  end

endmodule

// File: tb/tb_cluster_link_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cluster_link_scheduler
//
// Directed bench for cluster_link_scheduler with the default parameters
// (DEPTH=32, BX_MAX=3564, MAX_AGE=4). The stimulus is one linear sequence of
// steps. Each comparison is an immediate assertion against a hand-computed
// value.
// -----------------------------------------------------------------------------
module tb_cluster_link_scheduler;

  logic        clock4x = 1'b0;
  logic        global_reset;
  logic        bc0;
  logic        resync;
  logic        latch_in;
  logic [7:0]  vpf_in;
  logic [87:0] adr_in;
  logic [23:0] cnt_in;
  logic        out_ready;
  logic        out_valid;
  logic [10:0] out_adr;
  logic [2:0]  out_cnt;
  logic [11:0] out_bx;
  logic [5:0]  fifo_level;
  logic [15:0] overflow_cnt;
  logic        running;

  int n_cmp = 0;
  int n_bad = 0;
  int got[$];

  always #5 clock4x = ~clock4x;

  cluster_link_scheduler #(
    .DEPTH  (32),
    .BX_MAX (3564),
    .MAX_AGE(4)
  ) dut (
    .clock4x     (clock4x),
    .global_reset(global_reset),
    .bc0         (bc0),
    .resync      (resync),
    .latch_in    (latch_in),
    .vpf_in      (vpf_in),
    .adr_in      (adr_in),
    .cnt_in      (cnt_in),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_adr     (out_adr),
    .out_cnt     (out_cnt),
    .out_bx      (out_bx),
    .fifo_level  (fifo_level),
    .overflow_cnt(overflow_cnt),
    .running     (running)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock4x);
    #1;
  endtask

  task automatic set_slot(input int i, input int adr, input int cnt);
    adr_in[11*i +: 11] = 11'(adr);
    cnt_in[3*i +: 3]   = 3'(cnt);
  endtask

  task automatic set_slots(input int base);
    for (int i = 0; i < 8; i++) set_slot(i, base + i, i);
  endtask

  // Record each accepted output address. out_ready must be held high.
  task automatic drain(input int max_cycles);
    got.delete();
    for (int c = 0; c < max_cycles; c++) begin
      if (out_valid) got.push_back(int'(out_adr));
      step();
    end
  endtask

  initial begin
    global_reset = 1'b1;
    bc0 = 1'b0; resync = 1'b0; latch_in = 1'b0; out_ready = 1'b0;
    vpf_in = 8'h00; adr_in = '0; cnt_in = '0;

    // ---------------- reset state ----------------
    step(); step();
    global_reset = 1'b0;
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_overflow", overflow_cnt, 0);
    check("rst_running", running, 0);
    check("rst_out_bx", out_bx, 0);
    check("rst_out_adr", out_adr, 0);

    // latch_in in IDLE is ignored
    vpf_in = 8'hFF; set_slots(600); latch_in = 1'b1;
    step();
    latch_in = 1'b0; vpf_in = 8'h00;
    check("idle_ignore_level", fifo_level, 0);

    // ---------------- basic load / latency ----------------
    bc0 = 1'b1;
    step();
    bc0 = 1'b0;
    check("bc0_running", running, 1);
    adr_in = '0; cnt_in = '0;
    set_slot(0, 5, 1); set_slot(2, 100, 2); set_slot(7, 1500, 7);
    vpf_in = 8'b1000_0101; latch_in = 1'b1; out_ready = 1'b1;
    step();                                  // edge N
    latch_in = 1'b0; vpf_in = 8'h00;
    check("lat_n_valid", out_valid, 0);
    check("lat_n_level", fifo_level, 3);
    step();                                  // edge N+1
    check("c0_valid", out_valid, 1);
    check("c0_adr", out_adr, 5);
    check("c0_cnt", out_cnt, 1);
    check("c0_bx", out_bx, 0);
    step();
    check("c1_valid", out_valid, 1);
    check("c1_adr", out_adr, 100);
    check("c1_cnt", out_cnt, 2);
    check("c1_bx", out_bx, 0);
    step();
    check("c2_valid", out_valid, 1);
    check("c2_adr", out_adr, 1500);
    check("c2_cnt", out_cnt, 7);
    check("c2_bx", out_bx, 0);
    step();
    check("c3_valid", out_valid, 0);
    check("c3_level", fifo_level, 0);
    check("c3_adr_hold", out_adr, 1500);

    // ---------------- fill and overflow ----------------
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_slots(8 * k); vpf_in = 8'hFF; latch_in = 1'b1;
      step();
    end
    latch_in = 1'b0; vpf_in = 8'h00;
    check("fill_level31", fifo_level, 31);
    check("fill_out_valid", out_valid, 1);
    check("fill_out_adr", out_adr, 0);
    check("fill_overflow0", overflow_cnt, 0);
    set_slots(32); vpf_in = 8'hFF; latch_in = 1'b1;
    step();
    latch_in = 1'b0; vpf_in = 8'h00;
    check("ovf_level32", fifo_level, 32);
    check("ovf_cnt7", overflow_cnt, 7);
    set_slots(100); vpf_in = 8'h03; latch_in = 1'b1;
    step();
    latch_in = 1'b0; vpf_in = 8'h00;
    check("full_level32", fifo_level, 32);
    check("full_ovf9", overflow_cnt, 9);
    out_ready = 1'b1;
    drain(40);
    check("fill_drain_count", got.size(), 33);
    for (int j = 0; j < 33; j++) begin
      check($sformatf("fill_drain_adr%0d", j), (got.size() > j) ? got[j] : -1, j);
    end
    check("fill_drain_level", fifo_level, 0);

    // ---------------- BX wrap ----------------
    bc0 = 1'b1;
    step();
    bc0 = 1'b0;
    vpf_in = 8'h00; latch_in = 1'b1;
    for (int n = 0; n < 3563; n++) step();
    adr_in = '0; cnt_in = '0;
    set_slot(0, 76, 3); vpf_in = 8'h01;
    step();                                  // tag 3563, counter wraps to 0
    set_slot(0, 77, 4);
    step();                                  // tag 0
    latch_in = 1'b0; vpf_in = 8'h00;
    check("wrap_last_adr", out_adr, 76);
    check("wrap_last_bx", out_bx, 3563);
    step();
    check("wrap_adr", out_adr, 77);
    check("wrap_bx0", out_bx, 0);
    step();
    bc0 = 1'b1; latch_in = 1'b1; vpf_in = 8'h01; set_slot(0, 78, 5);
    step();                                  // bc0 + latch: tag 0, counter 1
    bc0 = 1'b0; set_slot(0, 79, 6);
    step();                                  // tag 1
    latch_in = 1'b0; vpf_in = 8'h00;
    check("bc0_latch_adr", out_adr, 78);
    check("bc0_latch_bx0", out_bx, 0);
    step();
    check("after_bc0_adr", out_adr, 79);
    check("after_bc0_bx1", out_bx, 1);
    step();

    // ---------------- resync / flush ----------------
    out_ready = 1'b0;
    set_slots(200); vpf_in = 8'hFF; latch_in = 1'b1;
    step();
    set_slots(208); vpf_in = 8'h03;
    step();
    latch_in = 1'b0; vpf_in = 8'h00;
    check("rs_level9", fifo_level, 9);
    check("rs_out_valid", out_valid, 1);
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("rs_running0", running, 0);
    set_slots(300); vpf_in = 8'hFF; latch_in = 1'b1; out_ready = 1'b1;
    drain(30);
    latch_in = 1'b0; vpf_in = 8'h00;
    check("rs_count10", got.size(), 10);
    for (int j = 0; j < 10; j++) begin
      check($sformatf("rs_adr%0d", j), (got.size() > j) ? got[j] : -1, 200 + j);
    end
    check("rs_end_running", running, 0);
    check("rs_end_level", fifo_level, 0);
    check("rs_end_valid", out_valid, 0);

    // ---------------- asynchronous reset mid-stream ----------------
    bc0 = 1'b1;
    step();
    bc0 = 1'b0;
    out_ready = 1'b0;
    set_slots(400); vpf_in = 8'hFF; latch_in = 1'b1;
    step();
    vpf_in = 8'h1F;
    step();
    latch_in = 1'b0; vpf_in = 8'h00;
    check("pre_rst_level12", fifo_level, 12);
    check("pre_rst_ovf9", overflow_cnt, 9);
    #2;
    global_reset = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_level", fifo_level, 0);
    check("async_rst_ovf", overflow_cnt, 0);
    check("async_rst_running", running, 0);
    step();
    global_reset = 1'b0;
    step();
    check("post_rst_level", fifo_level, 0);

    // ---------------- age handling ----------------
    bc0 = 1'b1;
    step();
    bc0 = 1'b0;
    out_ready = 1'b0;
    adr_in = '0; cnt_in = '0;
    vpf_in = 8'h01; latch_in = 1'b1;
    set_slot(0, 10, 1); step();              // tag 0
    set_slot(0, 11, 1); step();              // tag 1
    set_slot(0, 12, 1); step();              // tag 2
    vpf_in = 8'h00;
    for (int n = 0; n < 4; n++) step();      // tags 3..6 empty
    vpf_in = 8'h01;
    set_slot(0, 13, 1); step();              // tag 7, counter now 8
    latch_in = 1'b0; vpf_in = 8'h00;
    out_ready = 1'b1;
    drain(12);
`ifdef CLUSTER_SCHED_AGE_DROP_EN
    check("age_count", got.size(), 2);
    check("age_adr0", (got.size() > 0) ? got[0] : -1, 10);
    check("age_adr1", (got.size() > 1) ? got[1] : -1, 13);
    check("age_ovf", overflow_cnt, 2);
`else
    check("age_count", got.size(), 4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("age_adr%0d", j), (got.size() > j) ? got[j] : -1, 10 + j);
    end
    check("age_ovf", overflow_cnt, 0);
`endif
    check("age_end_level", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
